btn_event_gen: RTL

- Consumes the debounced, clock-synchronous button/switch levels from the debouncer stage.
- Per bit, produces one-cycle press, release, long-press and auto-repeat pulses.
- Also serialises all events into a single-entry event register with a valid/ack handshake for the GPIO register interface / MicroBlaze polling logic.
- Overflow is flagged when an event cannot be captured.

---
 rtl/btn_event_gen.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/btn_event_gen.sv
// Per-bit press/release/long/repeat pulse generator for debounced buttons, with a
// single-entry event register (valid/ack handshake) and a sticky overflow flag.
module btn_event_gen #(
    parameter int PORT_WIDTH    = 4,
    parameter int IDX_W         = 2,
    parameter int LONG_CLOCKS   = 1 << 24,
    parameter int REPEAT_CLOCKS = 1 << 22
) (
    input  logic                  CLK_I,
    input  logic                  RST_I,
    input  logic [PORT_WIDTH-1:0] SIGNAL_I,
    output logic [PORT_WIDTH-1:0] PRESS_O,
    output logic [PORT_WIDTH-1:0] RELEASE_O,
    output logic [PORT_WIDTH-1:0] LONG_O,
    output logic [PORT_WIDTH-1:0] REPEAT_O,
    output logic                  EVT_VALID_O,
    output logic [1:0]            EVT_TYPE_O,
    output logic [IDX_W-1:0]      EVT_IDX_O,
    input  logic                  EVT_ACK_I,
    output logic                  EVT_OVF_O,
    input  logic                  OVF_CLR_I
);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_HELD      = 2'd1;
    localparam logic [1:0] ST_REPEATING = 2'd2;

    localparam logic [1:0] EVT_PRESS    = 2'b00;
    localparam logic [1:0] EVT_RELEASE  = 2'b01;
    localparam logic [1:0] EVT_LONG     = 2'b10;
    localparam logic [1:0] EVT_REPEAT   = 2'b11;

    // The press edge loads the counter with 1, so LONG fires when it reaches LONG_CLOCKS.
    localparam logic [31:0] LONG_TC   = 32'(LONG_CLOCKS);
    localparam logic [31:0] REPEAT_TC = 32'(REPEAT_CLOCKS - 1);

    logic [PORT_WIDTH-1:0] prev_r;
    logic [1:0]            state_r [PORT_WIDTH];
    logic [31:0]           cnt_r   [PORT_WIDTH];
    logic [1:0]            state_s [PORT_WIDTH];
    logic [31:0]           cnt_s   [PORT_WIDTH];

    logic [PORT_WIDTH-1:0] press_s;
    logic [PORT_WIDTH-1:0] release_s;
    logic [PORT_WIDTH-1:0] long_s;
    logic [PORT_WIDTH-1:0] repeat_s;
    logic [PORT_WIDTH-1:0] evt_s;
    logic [PORT_WIDTH-1:0] first_s;
    logic [PORT_WIDTH-1:0] drop_s;
    logic                  free_s;
    logic [1:0]            sel_type_s;
    logic [IDX_W-1:0]      sel_idx_s;

    function automatic logic [1:0] evt_type(input logic p, input logic r, input logic l);
        logic [1:0] t;
        if (p) begin
            t = EVT_PRESS;
        end else if (r) begin
            t = EVT_RELEASE;
        end else if (l) begin
            t = EVT_LONG;
        end else begin
            t = EVT_REPEAT;
        end
        return t;
    endfunction

    // Per-bit next-state and pulse decisions; release always beats an expiring counter.
    always_comb begin
        for (int i = 0; i < PORT_WIDTH; i++) begin
            state_s[i]   = state_r[i];
            cnt_s[i]     = cnt_r[i];
            press_s[i]   = 1'b0;
            release_s[i] = 1'b0;
            long_s[i]    = 1'b0;
            repeat_s[i]  = 1'b0;
            case (state_r[i])
                ST_IDLE: begin
                    if (SIGNAL_I[i] && !prev_r[i]) begin
                        press_s[i] = 1'b1;
                        cnt_s[i]   = 32'd1;
                        state_s[i] = ST_HELD;
                    end else begin
                        cnt_s[i]   = 32'd0;
                    end
                end
                ST_HELD: begin
                    if (!SIGNAL_I[i]) begin
                        release_s[i] = 1'b1;
                        cnt_s[i]     = 32'd0;
                        state_s[i]   = ST_IDLE;
                    end else if (cnt_r[i] == LONG_TC) begin
                        long_s[i]    = 1'b1;
                        cnt_s[i]     = 32'd0;
                        state_s[i]   = ST_REPEATING;
                    end else begin
                        cnt_s[i]     = cnt_r[i] + 32'd1;
                    end
                end
                ST_REPEATING: begin
                    if (!SIGNAL_I[i]) begin
                        release_s[i] = 1'b1;
                        cnt_s[i]     = 32'd0;
                        state_s[i]   = ST_IDLE;
                    end else if (cnt_r[i] == REPEAT_TC) begin
                        repeat_s[i]  = 1'b1;
                        cnt_s[i]     = 32'd0;
                    end else begin
                        cnt_s[i]     = cnt_r[i] + 32'd1;
                    end
                end
                default: begin
                    cnt_s[i]   = 32'd0;
                    state_s[i] = ST_IDLE;
                end
            endcase
        end
    end

    // Lowest-index event wins the register slot; everything else that cycle is a drop.
    always_comb begin
        evt_s      = press_s | release_s | long_s | repeat_s;
        first_s    = evt_s & (~evt_s + PORT_WIDTH'(1));
        free_s     = !EVT_VALID_O || EVT_ACK_I;
        drop_s     = free_s ? (evt_s & ~first_s) : evt_s;
        sel_idx_s  = '0;
        sel_type_s = EVT_PRESS;
        for (int i = PORT_WIDTH - 1; i >= 0; i--) begin
            sel_idx_s  = evt_s[i] ? IDX_W'(i) : sel_idx_s;
            sel_type_s = evt_s[i] ? evt_type(press_s[i], release_s[i], long_s[i]) : sel_type_s;
        end
    end

    // State, counters, registered pulses and the event/overflow registers.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            prev_r      <= '0;
            PRESS_O     <= '0;
            RELEASE_O   <= '0;
            LONG_O      <= '0;
            REPEAT_O    <= '0;
            EVT_VALID_O <= 1'b0;
            EVT_TYPE_O  <= 2'b00;
            EVT_IDX_O   <= '0;
            EVT_OVF_O   <= 1'b0;
            for (int i = 0; i < PORT_WIDTH; i++) begin
                state_r[i] <= ST_IDLE;
                cnt_r[i]   <= 32'd0;
            end
        end else begin
            prev_r    <= SIGNAL_I;
            PRESS_O   <= press_s;
            RELEASE_O <= release_s;
            LONG_O    <= long_s;
            REPEAT_O  <= repeat_s;
            for (int i = 0; i < PORT_WIDTH; i++) begin
                state_r[i] <= state_s[i];
                cnt_r[i]   <= cnt_s[i];
            end
            if (free_s && (|evt_s)) begin
                EVT_VALID_O <= 1'b1;
                EVT_TYPE_O  <= sel_type_s;
                EVT_IDX_O   <= sel_idx_s;
            end else if (EVT_VALID_O && EVT_ACK_I) begin
                EVT_VALID_O <= 1'b0;
            end else begin
                EVT_VALID_O <= EVT_VALID_O;
            end
            EVT_OVF_O <= (|drop_s) | (EVT_OVF_O & ~OVF_CLR_I);
        end
    end

endmodule
